// File: rtl/btn_gesture_pkg.sv
// Shared definitions for the push-button gesture decoder: FSM state encoding
// and default tick constants.
package btn_gesture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_PRESSED        = 3'd1,
      ST_LONG_HELD      = 3'd2,
      ST_WAIT_SECOND    = 3'd3,
      ST_SECOND_PRESSED = 3'd4
   } gesture_state_t;

   localparam int LP_DEF_CNT_WIDTH    = 16;
   localparam int LP_DEF_LONG_TICKS   = 50000;
   localparam int LP_DEF_DOUBLE_TICKS = 20000;
   localparam int LP_DEF_REPEAT_TICKS = 10000;

endpackage

// File: rtl/level_edge_detect.sv
// Registers a clean synchronous level and produces one-sample rise/fall strobes.
// Reusable for any debounced input.
module level_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_rise = i_level & ~r_prev;
   assign o_fall = ~i_level & r_prev;

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies a debounced button level into one-cycle press/release/short/long/
// repeat/double events using a single shared saturating cycle counter.
module button_gesture_decoder
   import btn_gesture_pkg::*;
#(
   parameter int p_CNT_WIDTH    = LP_DEF_CNT_WIDTH,
   parameter int p_LONG_TICKS   = LP_DEF_LONG_TICKS,
   parameter int p_DOUBLE_TICKS = LP_DEF_DOUBLE_TICKS,
   parameter int p_REPEAT_TICKS = LP_DEF_REPEAT_TICKS
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   output logic o_press,
   output logic o_release,
   output logic o_short,
   output logic o_long,
   output logic o_repeat,
   output logic o_double,
   output logic o_busy
);

   if (p_LONG_TICKS < 2 || p_DOUBLE_TICKS < 2 || p_REPEAT_TICKS < 2) begin : g_bad_ticks
      $error("button_gesture_decoder: tick parameters must be >= 2");
   end

   if ((2 ** p_CNT_WIDTH) - 1 < p_LONG_TICKS ||
       (2 ** p_CNT_WIDTH) - 1 < p_DOUBLE_TICKS ||
       (2 ** p_CNT_WIDTH) - 1 < p_REPEAT_TICKS) begin : g_bad_width
      $error("button_gesture_decoder: p_CNT_WIDTH too small for tick parameters");
   end

   localparam logic [p_CNT_WIDTH-1:0] lp_LONG_LAST   = p_CNT_WIDTH'(p_LONG_TICKS - 1);
   localparam logic [p_CNT_WIDTH-1:0] lp_DOUBLE_LAST = p_CNT_WIDTH'(p_DOUBLE_TICKS - 1);
   localparam logic [p_CNT_WIDTH-1:0] lp_REPEAT_LAST = p_CNT_WIDTH'(p_REPEAT_TICKS - 1);

   function automatic logic [p_CNT_WIDTH-1:0] f_sat_inc(input logic [p_CNT_WIDTH-1:0] i_v);
      return (i_v == {p_CNT_WIDTH{1'b1}}) ? i_v : i_v + 1'b1;
   endfunction

   logic w_rise;
   logic w_fall;

   gesture_state_t         r_state;
   gesture_state_t         w_state_nxt;
   logic [p_CNT_WIDTH-1:0] r_cnt;
   logic [p_CNT_WIDTH-1:0] w_cnt_nxt;

   logic w_press, w_release, w_short, w_long, w_repeat, w_double;
   logic r_press, r_release, r_short, r_long, r_repeat, r_double, r_busy;

   level_edge_detect u_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_level (i_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // Fall beats the long threshold and rise beats the double-click timeout
   // because each is tested first within its state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = f_sat_inc(r_cnt);
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_short     = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      w_double    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_rise) begin
               w_state_nxt = ST_PRESSED;
               w_press     = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (w_fall) begin
               w_state_nxt = ST_WAIT_SECOND;
               w_cnt_nxt   = '0;
               w_release   = 1'b1;
            end else if (i_level && r_cnt == lp_LONG_LAST) begin
               w_state_nxt = ST_LONG_HELD;
               w_cnt_nxt   = '0;
               w_long      = 1'b1;
            end
         end
         ST_LONG_HELD: begin
            if (w_fall) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_release   = 1'b1;
            end else if (r_cnt == lp_REPEAT_LAST) begin
               w_cnt_nxt = '0;
               w_repeat  = 1'b1;
            end
         end
         ST_WAIT_SECOND: begin
            if (w_rise && r_cnt <= lp_DOUBLE_LAST) begin
               w_state_nxt = ST_SECOND_PRESSED;
               w_cnt_nxt   = '0;
               w_press     = 1'b1;
               w_double    = 1'b1;
            end else if (r_cnt == lp_DOUBLE_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_short     = 1'b1;
            end
         end
         ST_SECOND_PRESSED: begin
            if (w_fall) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_release   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_short   <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         r_double  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_press   <= w_press;
         r_release <= w_release;
         r_short   <= w_short;
         r_long    <= w_long;
         r_repeat  <= w_repeat;
         r_double  <= w_double;
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_short   = r_short;
   assign o_long    = r_long;
   assign o_repeat  = r_repeat;
   assign o_double  = r_double;
   assign o_busy    = r_busy;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with small tick parameters; every
// cycle's event vector {press,release,short,long,repeat,double} is hand-derived.
module tb_button_gesture_decoder;

   localparam logic [5:0] EV_0  = 6'b000000;
   localparam logic [5:0] EV_P  = 6'b100000;
   localparam logic [5:0] EV_R  = 6'b010000;
   localparam logic [5:0] EV_S  = 6'b001000;
   localparam logic [5:0] EV_L  = 6'b000100;
   localparam logic [5:0] EV_RP = 6'b000010;
   localparam logic [5:0] EV_PD = 6'b100001;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic level = 1'b0;
   logic o_press, o_release, o_short, o_long, o_repeat, o_double, o_busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   button_gesture_decoder #(
      .p_CNT_WIDTH    (4),
      .p_LONG_TICKS   (8),
      .p_DOUBLE_TICKS (6),
      .p_REPEAT_TICKS (4)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_level   (level),
      .o_press   (o_press),
      .o_release (o_release),
      .o_short   (o_short),
      .o_long    (o_long),
      .o_repeat  (o_repeat),
      .o_double  (o_double),
      .o_busy    (o_busy)
   );

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
      end
   endtask

   // Apply one level sample, let the clock edge take it, then check the events.
   task automatic stp(input logic lvl, input logic [5:0] exp_ev, input string tag);
      level = lvl;
      @(posedge clk);
      #1;
      chk(tag, {2'b00, o_press, o_release, o_short, o_long, o_repeat, o_double},
          {2'b00, exp_ev});
   endtask

   task automatic stp_n(input int n, input logic lvl, input string tag);
      for (int k = 0; k < n; k++) stp(lvl, EV_0, tag);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_events", {2'b00, o_press, o_release, o_short, o_long, o_repeat, o_double}, 8'h00);
      chk("rst_busy", {7'b0, o_busy}, 8'h00);
      rst_n = 1'b1;
      stp_n(3, 1'b0, "idle");

      // Short click: 3 highs, then lows; short on the 7th low sample.
      stp(1'b1, EV_P, "s1_press");
      stp_n(2, 1'b1, "s1_hold");
      stp(1'b0, EV_R, "s1_release");
      stp_n(5, 1'b0, "s1_wait");
      chk("s1_busy_wait", {7'b0, o_busy}, 8'h01);
      stp(1'b0, EV_S, "s1_short");
      chk("s1_busy_idle", {7'b0, o_busy}, 8'h00);
      stp_n(13, 1'b0, "s1_tail");

      // 8 highs: the fall lands on the long-threshold edge, so it stays short-path.
      stp(1'b1, EV_P, "s6_press");
      stp_n(7, 1'b1, "s6_hold");
      stp(1'b0, EV_R, "s6_release");
      chk("s6_busy", {7'b0, o_busy}, 8'h01);
      stp_n(5, 1'b0, "s6_wait");
      stp(1'b0, EV_S, "s6_short");
      stp_n(2, 1'b0, "s6_idle");

      // Same again, but a rise after 2 lows proves the FSM sat in WAIT_SECOND.
      stp(1'b1, EV_P, "s6b_press");
      stp_n(7, 1'b1, "s6b_hold");
      stp(1'b0, EV_R, "s6b_release");
      stp(1'b0, EV_0, "s6b_low");
      stp(1'b1, EV_PD, "s6b_double");
      stp(1'b0, EV_R, "s6b_release2");
      stp_n(8, 1'b0, "s6b_tail");

      // 9 highs: long on the 9th sample, then release without short.
      stp(1'b1, EV_P, "s2_press");
      stp_n(7, 1'b1, "s2_hold");
      stp(1'b1, EV_L, "s2_long");
      stp(1'b0, EV_R, "s2_release");
      chk("s2_busy", {7'b0, o_busy}, 8'h00);
      stp_n(8, 1'b0, "s2_tail");

      // Repeat: 22 highs -> long at H9, repeats at H13, H17, H21.
      stp(1'b1, EV_P, "s3_press");
      stp_n(7, 1'b1, "s3_hold");
      stp(1'b1, EV_L, "s3_long");
      for (int r = 0; r < 3; r++) begin
         stp_n(3, 1'b1, "s3_gap");
         stp(1'b1, EV_RP, "s3_repeat");
      end
      stp(1'b1, EV_0, "s3_last_high");
      stp(1'b0, EV_R, "s3_release");
      stp_n(8, 1'b0, "s3_tail");

      // Double click with a 4-low gap.
      stp(1'b1, EV_P, "s4a_press");
      stp(1'b1, EV_0, "s4a_hold");
      stp(1'b0, EV_R, "s4a_release");
      stp_n(3, 1'b0, "s4a_gap");
      stp(1'b1, EV_PD, "s4a_double");
      stp(1'b1, EV_0, "s4a_hold2");
      stp(1'b0, EV_R, "s4a_release2");
      stp_n(8, 1'b0, "s4a_tail");

      // 6-low gap: rise lands on the timeout edge and wins.
      stp(1'b1, EV_P, "s4b_press");
      stp(1'b1, EV_0, "s4b_hold");
      stp(1'b0, EV_R, "s4b_release");
      stp_n(5, 1'b0, "s4b_gap");
      stp(1'b1, EV_PD, "s4b_double");
      stp(1'b1, EV_0, "s4b_hold2");
      stp(1'b0, EV_R, "s4b_release2");
      stp_n(8, 1'b0, "s4b_tail");

      // 7-low gap: short fires, then the rise is a fresh press.
      stp(1'b1, EV_P, "s4c_press");
      stp(1'b1, EV_0, "s4c_hold");
      stp(1'b0, EV_R, "s4c_release");
      stp_n(5, 1'b0, "s4c_gap");
      stp(1'b0, EV_S, "s4c_short");
      stp(1'b1, EV_P, "s4c_fresh_press");
      stp(1'b1, EV_0, "s4c_hold2");
      stp(1'b0, EV_R, "s4c_release2");
      stp_n(5, 1'b0, "s4c_wait");
      stp(1'b0, EV_S, "s4c_short2");
      stp_n(2, 1'b0, "s4c_tail");

      // Reset while in LONG_HELD with o_long still high.
      stp(1'b1, EV_P, "s5_press");
      stp_n(7, 1'b1, "s5_hold");
      stp(1'b1, EV_L, "s5_long");
      chk("s5_busy_pre", {7'b0, o_busy}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s5_rst_events", {2'b00, o_press, o_release, o_short, o_long, o_repeat, o_double}, 8'h00);
      chk("s5_rst_busy", {7'b0, o_busy}, 8'h00);
      repeat (2) @(posedge clk);
      #4;
      rst_n = 1'b1;
      stp(1'b1, EV_P, "s5_press_after_rst");
      chk("s5_busy_post", {7'b0, o_busy}, 8'h01);
      stp(1'b0, EV_R, "s5_release");
      stp_n(5, 1'b0, "s5_wait");
      stp(1'b0, EV_S, "s5_short");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
